dmem_resp: RTL and testbench

- Multi-cycle data-memory responder: the memory-side end of the MIPS load/store interface.
- Replaces the zero-latency dmem with a valid/ready request channel, programmable wait states and a stall output that freezes the pipeline until the response arrives.
- Sits between the mips datapath (aluout/writedata/memwrite) and the word-addressed data RAM.
- Flags misaligned and out-of-range accesses.

---
 rtl/dmem_resp.sv | 164 ++++++++++++++++
 tb/tb_dmem_resp.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// Multi-cycle word-addressed data memory: valid/ready request, WAIT_CYCLES wait states, one-cycle response strobe.
// Optional DMEM_PERF_EN builds load/store/stall counters; otherwise the perf ports read zero.
module dmem_resp #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall,
    output logic [31:0] perf_reads,
    output logic [31:0] perf_writes,
    output logic [31:0] perf_waits
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          commit;
    logic          c_we;
    logic [31:0]   c_addr;
    logic [31:0]   c_wdata;
    logic [AW-1:0] c_idx;
    logic          c_err;
    logic          mem_we;

    assign accept = req_valid && (state_q == S_IDLE);

    // With zero wait states the commit edge is the acceptance edge, so the live request is used.
    assign c_we    = (state_q == S_IDLE) ? req_we    : we_q;
    assign c_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign c_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign c_idx   = c_addr[AW+1:2];
    assign c_err   = (|c_addr[1:0]) || (|c_addr[31:AW+2]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign commit = (state_d == S_RESP);
    assign mem_we = commit && c_we && !c_err;

    always_comb begin
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            we_d    = req_we;
            addr_d  = req_addr;
            wdata_d = req_wdata;
        end
        if (commit) begin
            rsp_err_d   = c_err;
            rsp_rdata_d = (c_we || c_err) ? 32'd0 : mem[c_idx];
        end
    end

    // Reset held across a commit edge must suppress the write.
    always_ff @(posedge clk or posedge reset) begin
        if (!reset && mem_we) begin
            mem[c_idx] <= c_wdata;
        end
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        stall     = req_valid && (state_q != S_RESP);
        rsp_rdata = rsp_rdata_q;
        rsp_err   = rsp_err_q;
    end

`ifdef DMEM_PERF_EN
    logic [31:0] perf_reads_q, perf_reads_d;
    logic [31:0] perf_writes_q, perf_writes_d;
    logic [31:0] perf_waits_q, perf_waits_d;

    always_comb begin
        perf_reads_d  = perf_reads_q  + {31'd0, accept && !req_we};
        perf_writes_d = perf_writes_q + {31'd0, accept && req_we};
        perf_waits_d  = perf_waits_q  + {31'd0, stall};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_reads_q  <= 32'd0;
            perf_writes_q <= 32'd0;
            perf_waits_q  <= 32'd0;
        end else begin
            perf_reads_q  <= perf_reads_d;
            perf_writes_q <= perf_writes_d;
            perf_waits_q  <= perf_waits_d;
        end
    end

    assign perf_reads  = perf_reads_q;
    assign perf_writes = perf_writes_q;
    assign perf_waits  = perf_waits_q;
`else
    assign perf_reads  = 32'd0;
    assign perf_writes = 32'd0;
    assign perf_waits  = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: instance a uses two wait states, instance b uses none.
module tb_dmem_resp;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic        a_req_valid, a_req_we, a_req_ready, a_rsp_valid, a_rsp_err, a_stall;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata, a_perf_reads, a_perf_writes, a_perf_waits;
    logic        b_req_valid, b_req_we, b_req_ready, b_rsp_valid, b_rsp_err, b_stall;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata, b_perf_reads, b_perf_writes, b_perf_waits;

    always #5 clk = ~clk;

    dmem_resp #(.DEPTH(64), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .req_ready(a_req_ready), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .stall(a_stall), .perf_reads(a_perf_reads), .perf_writes(a_perf_writes), .perf_waits(a_perf_waits)
    );

    dmem_resp #(.DEPTH(64), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .stall(b_stall), .perf_reads(b_perf_reads), .perf_writes(b_perf_writes), .perf_waits(b_perf_waits)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit b, input logic v, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (b) begin
            b_req_valid = v; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata;
        end else begin
            a_req_valid = v; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
        end
    endtask

    task automatic sample(input bit b, output logic rv, output logic rdy, output logic stl,
                          output logic err, output logic [31:0] rd);
        rv  = b ? b_rsp_valid : a_rsp_valid;
        rdy = b ? b_req_ready : a_req_ready;
        stl = b ? b_stall     : a_stall;
        err = b ? b_rsp_err   : a_rsp_err;
        rd  = b ? b_rsp_rdata : a_rsp_rdata;
    endtask

    // Called just after a falling edge with the chosen instance idle.
    task automatic access(input bit b, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err, input string tag);
        int w;
        logic rv, rdy, stl, err;
        logic [31:0] rd;
        w = b ? 0 : 2;
        drive(b, 1'b1, we, addr, wdata);
        #1;
        sample(b, rv, rdy, stl, err, rd);
        chk({tag, " idle stall"}, {31'd0, stl}, 32'd1);
        chk({tag, " idle ready"}, {31'd0, rdy}, 32'd1);
        for (int k = 0; k < w; k++) begin
            @(posedge clk); @(negedge clk);
            sample(b, rv, rdy, stl, err, rd);
            chk({tag, " wait stall"}, {31'd0, stl}, 32'd1);
            chk({tag, " wait rsp_valid"}, {31'd0, rv}, 32'd0);
            chk({tag, " wait ready"}, {31'd0, rdy}, 32'd0);
        end
        @(posedge clk); @(negedge clk);
        sample(b, rv, rdy, stl, err, rd);
        chk({tag, " resp rsp_valid"}, {31'd0, rv}, 32'd1);
        chk({tag, " resp stall"}, {31'd0, stl}, 32'd0);
        chk({tag, " resp ready"}, {31'd0, rdy}, 32'd0);
        chk({tag, " resp rdata"}, rd, exp_rd);
        chk({tag, " resp err"}, {31'd0, err}, {31'd0, exp_err});
        @(posedge clk); @(negedge clk);
        sample(b, rv, rdy, stl, err, rd);
        chk({tag, " after rsp_valid"}, {31'd0, rv}, 32'd0);
        chk({tag, " after ready"}, {31'd0, rdy}, 32'd1);
        chk({tag, " after rdata hold"}, rd, exp_rd);
        drive(b, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        sample(b, rv, rdy, stl, err, rd);
        chk({tag, " released stall"}, {31'd0, stl}, 32'd0);
    endtask

    task automatic chk_perf(input string tag, input logic [31:0] r, input logic [31:0] w, input logic [31:0] s);
`ifdef DMEM_PERF_EN
        chk({tag, " perf_reads"}, a_perf_reads, r);
        chk({tag, " perf_writes"}, a_perf_writes, w);
        chk({tag, " perf_waits"}, a_perf_waits, s);
`else
        chk({tag, " perf_reads tied"}, a_perf_reads, 32'd0 & r);
        chk({tag, " perf_writes tied"}, a_perf_writes, 32'd0 & w);
        chk({tag, " perf_waits tied"}, a_perf_waits, 32'd0 & s);
`endif
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk); @(negedge clk);
        chk("reset ready", {31'd0, a_req_ready}, 32'd1);
        chk("reset rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        chk("reset stall", {31'd0, a_stall}, 32'd0);
        chk("reset rdata", a_rsp_rdata, 32'd0);
        chk("reset err", {31'd0, a_rsp_err}, 32'd0);
        chk_perf("reset", 32'd0, 32'd0, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Zero wait states.
        access(1'b1, 1'b1, 32'h04, 32'h12345678, 32'h0, 1'b0, "b store 04");
        access(1'b1, 1'b0, 32'h04, 32'h0, 32'h12345678, 1'b0, "b load 04");
`ifdef DMEM_PERF_EN
        chk("b perf_reads", b_perf_reads, 32'd1);
        chk("b perf_writes", b_perf_writes, 32'd1);
        chk("b perf_waits", b_perf_waits, 32'd2);
`endif

        // Two wait states.
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "a store 10");
        access(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "a load 10");
        access(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, "a store 20");
        access(1'b0, 1'b1, 32'h22, 32'hFFFFFFFF, 32'h0, 1'b1, "a misaligned store 22");
        access(1'b0, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, "a load 20");
        access(1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, "a oob load 100");
        access(1'b0, 1'b1, 32'h08, 32'h11112222, 32'h0, 1'b0, "a store 08");
        access(1'b0, 1'b0, 32'h08, 32'h0, 32'h11112222, 1'b0, "a load 08");
        chk_perf("before reset", 32'd4, 32'd4, 32'd24);

        // Reset one cycle after accepting a store.
        drive(1'b0, 1'b1, 1'b1, 32'h08, 32'hAAAA5555);
        @(posedge clk); @(negedge clk);
        chk("rst wait stall", {31'd0, a_stall}, 32'd1);
        chk("rst wait ready", {31'd0, a_req_ready}, 32'd0);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("rst ready", {31'd0, a_req_ready}, 32'd1);
        chk("rst stall", {31'd0, a_stall}, 32'd0);
        chk("rst rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        chk("rst rdata", a_rsp_rdata, 32'd0);
        chk_perf("rst", 32'd0, 32'd0, 32'd0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post-rst idle rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
            chk("post-rst idle stall", {31'd0, a_stall}, 32'd0);
            chk("post-rst idle ready", {31'd0, a_req_ready}, 32'd1);
        end
        access(1'b0, 1'b0, 32'h08, 32'h0, 32'h11112222, 1'b0, "a load 08 after rst");
        chk_perf("after rst load", 32'd1, 32'd0, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
